// File: rtl/prelude_alu_sequencer.sv
// Prelude ALU initiator: decodes instruction bytes, owns R0..R5, sequences the external ALU.
// Optional flags (flag_zero/flag_neg) are built when PRELUDE_ALU_FLAGS_EN is defined.
module prelude_alu_sequencer #(
   parameter int DATA_W   = 8,
   parameter int OP_W     = 6,
   parameter int NUM_REGS = 6
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [7:0]        instr,
   input  logic              instr_valid,
   output logic              instr_ready,
   output logic [OP_W-1:0]   alu_op,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   input  logic [DATA_W-1:0] alu_out,
   input  logic [DATA_W-1:0] in_port,
   output logic [DATA_W-1:0] out_port,
`ifdef PRELUDE_ALU_FLAGS_EN
   output logic              flag_zero,
   output logic              flag_neg,
`endif
   output logic              out_valid
);

   typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

   state_t            state;
   logic [OP_W-1:0]   op;
   logic [DATA_W-1:0] res;
   logic [DATA_W-1:0] regs [NUM_REGS];
   logic [DATA_W-1:0] src_val;
   logic [2:0]        src_sel;
   logic [2:0]        dst_sel;
   logic              xfer;

   assign src_sel = instr[5:3];
   assign dst_sel = instr[2:0];

   // Ready and ALU drive are gated by rst_n so they read 0 for the whole reset cycle.
   assign instr_ready = rst_n && (state == IDLE);
   assign xfer        = instr_valid && instr_ready;
   assign alu_op      = (rst_n && state == EXEC) ? op      : '0;
   assign alu_a       = (rst_n && state == EXEC) ? regs[1] : '0;
   assign alu_b       = (rst_n && state == EXEC) ? regs[2] : '0;

   always_comb begin
      src_val = '0;
      case (src_sel)
         3'd6:    src_val = in_port;
         3'd7:    src_val = '0;
         default: src_val = regs[src_sel];
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         op        <= '0;
         res       <= '0;
         out_port  <= '0;
         out_valid <= 1'b0;
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
`ifdef PRELUDE_ALU_FLAGS_EN
         flag_zero <= 1'b0;
         flag_neg  <= 1'b0;
`endif
      end else begin
         out_valid <= 1'b0;
         case (state)
            // IDLE: decode at the transfer edge
            IDLE: begin
               if (xfer) begin
                  case (instr[7:6])
                     2'b00: regs[0] <= DATA_W'(instr[5:0]);
                     2'b01: begin
                        op    <= OP_W'(instr[2:0]);
                        state <= EXEC;
                     end
                     2'b10: begin
                        case (dst_sel)
                           3'd6: begin
                              out_port  <= src_val;
                              out_valid <= 1'b1;
                           end
                           3'd7:    ;
                           default: regs[dst_sel] <= src_val;
                        endcase
                     end
                     default: ;
                  endcase
               end
            end
            // EXEC: operands are on the ALU; capture its result
            EXEC: begin
               res   <= alu_out;
               state <= WB;
            end
            // WB: commit the captured result to R3
            WB: begin
               regs[3] <= res;
`ifdef PRELUDE_ALU_FLAGS_EN
               flag_zero <= (res == '0);
               flag_neg  <= res[DATA_W-1];
`endif
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_prelude_alu_sequencer.sv
// Directed bench for prelude_alu_sequencer: vector table plus hand-written reset/EXEC/port sequences.
module tb_prelude_alu_sequencer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] instr = '0;
   logic       instr_valid = 1'b0;
   logic       instr_ready;
   logic [5:0] alu_op;
   logic [7:0] alu_a, alu_b, alu_out;
   logic [7:0] in_port = '0;
   logic [7:0] out_port;
   logic       out_valid;
`ifdef PRELUDE_ALU_FLAGS_EN
   logic       flag_zero, flag_neg;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   prelude_alu_sequencer dut (
      .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
      .instr_ready(instr_ready), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
      .alu_out(alu_out), .in_port(in_port), .out_port(out_port),
`ifdef PRELUDE_ALU_FLAGS_EN
      .flag_zero(flag_zero), .flag_neg(flag_neg),
`endif
      .out_valid(out_valid)
   );

   // Reference ALU the sequencer talks to
   always_comb begin
      case (alu_op)
         6'd0:    alu_out = alu_a;
         6'd1:    alu_out = alu_b;
         6'd2:    alu_out = alu_a | alu_b;
         6'd3:    alu_out = alu_a & alu_b;
         6'd4:    alu_out = alu_a + alu_b;
         6'd5:    alu_out = alu_a - alu_b;
         6'd6:    alu_out = alu_a ^ alu_b;
         default: alu_out = ~alu_a;
      endcase
   end

   typedef struct {
      logic [7:0] ins;
      logic [7:0] pin;
      int         reg_no;
      logic [7:0] exp;
   } vec_t;

   vec_t tbl [13];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!instr_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!instr_ready) check("ready_timeout", 32'(instr_ready), 32'd1);
   endtask

   // Present a byte, hold it until accepted, return #1 after the transfer edge
   task automatic send(input logic [7:0] b);
      @(negedge clk);
      instr = b;
      instr_valid = 1'b1;
      wait_ready();
      @(posedge clk);
      #1;
      instr_valid = 1'b0;
   endtask

   task automatic read_reg(input int n, output logic [7:0] v);
      logic [2:0] s;
      s = 3'(n);
      @(negedge clk);
      wait_ready();
      send({2'b10, s, 3'b110});
      v = out_port;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      instr_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      logic [7:0] v;
      int cnt;

      tbl[0]  = '{8'h05, 8'h00, 0, 8'h05};
      tbl[1]  = '{8'h81, 8'h00, 1, 8'h05};
      tbl[2]  = '{8'h03, 8'h00, 0, 8'h03};
      tbl[3]  = '{8'h82, 8'h00, 2, 8'h03};
      tbl[4]  = '{8'h44, 8'h00, 3, 8'h08};
      tbl[5]  = '{8'h9D, 8'h00, 5, 8'h08};
      tbl[6]  = '{8'h3F, 8'h00, 0, 8'h3F};
      tbl[7]  = '{8'hB4, 8'h5A, 4, 8'h5A};
      tbl[8]  = '{8'h45, 8'h00, 3, 8'h02};
      tbl[9]  = '{8'h46, 8'h00, 3, 8'h06};
      tbl[10] = '{8'hA1, 8'h00, 1, 8'h5A};
      tbl[11] = '{8'h42, 8'h00, 3, 8'h5B};
      tbl[12] = '{8'hB9, 8'h00, 1, 8'h00};

      // Reset behaviour
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_ready", 32'(instr_ready), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_alu_op", 32'(alu_op), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("post_rst_ready", 32'(instr_ready), 32'd1);
      for (int i = 0; i < 6; i++) begin
         read_reg(i, v);
         check($sformatf("rst_R%0d", i), 32'(v), 32'd0);
      end

      // Program 0x05,0x81,0x03,0x82,0x44 with EXEC visibility and ready-low count
      send(8'h05); send(8'h81); send(8'h03); send(8'h82);
      send(8'h44);
      check("exec_alu_op", 32'(alu_op), 32'd4);
      check("exec_alu_a", 32'(alu_a), 32'd5);
      check("exec_alu_b", 32'(alu_b), 32'd3);
      cnt = 0;
      while (!instr_ready && cnt < 10) begin
         cnt++;
         @(posedge clk);
         #1;
         if (cnt == 1) check("wb_alu_op", 32'(alu_op), 32'd0);
      end
      check("ready_low_cycles", 32'(cnt), 32'd2);
      read_reg(3, v);
      check("add_R3", 32'(v), 32'h08);

      // Vector table from a clean reset
      do_reset();
      for (int i = 0; i < 13; i++) begin
         in_port = tbl[i].pin;
         send(tbl[i].ins);
         read_reg(tbl[i].reg_no, v);
         check($sformatf("vec%0d_R%0d", i, tbl[i].reg_no), 32'(v), 32'(tbl[i].exp));
      end

      // SUB wrap, AND, XOR-to-zero with flags
      do_reset();
      send(8'h03); send(8'h81); send(8'h05); send(8'h82);
      send(8'h45);
      read_reg(3, v);
      check("sub_wrap_R3", 32'(v), 32'hFE);
`ifdef PRELUDE_ALU_FLAGS_EN
      check("sub_flag_neg", 32'(flag_neg), 32'd1);
      check("sub_flag_zero", 32'(flag_zero), 32'd0);
`endif
      send(8'h0F); send(8'h81); send(8'h82);
      send(8'h43);
      read_reg(3, v);
      check("and_R3", 32'(v), 32'h0F);
      send(8'h46);
      read_reg(3, v);
      check("xor_R3", 32'(v), 32'h00);
`ifdef PRELUDE_ALU_FLAGS_EN
      check("xor_flag_zero", 32'(flag_zero), 32'd1);
      check("xor_flag_neg", 32'(flag_neg), 32'd0);
      send(8'h21);
      check("imm_keeps_flag_zero", 32'(flag_zero), 32'd1);
`endif

      // in_port -> out_port pulse, then zero source
      in_port = 8'hA5;
      send(8'hB6);
      check("port_out", 32'(out_port), 32'hA5);
      check("port_valid_hi", 32'(out_valid), 32'd1);
      @(posedge clk);
      #1;
      check("port_valid_lo", 32'(out_valid), 32'd0);
      check("port_hold", 32'(out_port), 32'hA5);
      send(8'hBE);
      check("port_zero", 32'(out_port), 32'h00);

      // Reset during EXEC with the COMP byte held valid
      do_reset();
      send(8'h05); send(8'h81);
      @(negedge clk);
      instr = 8'h44;
      instr_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check("abort_ready", 32'(instr_ready), 32'd0);
      check("abort_alu_op", 32'(alu_op), 32'd0);
      check("abort_out_valid", 32'(out_valid), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("abort_idle", 32'(instr_ready), 32'd1);
      @(posedge clk);
      #1;
      instr_valid = 1'b0;
      check("reaccept_alu_op", 32'(alu_op), 32'd4);
      check("reaccept_alu_a", 32'(alu_a), 32'd0);
      read_reg(3, v);
      check("abort_R3", 32'(v), 32'h00);

      // Reserved byte and null-destination copy are single-cycle no-ops
      do_reset();
      send(8'h2A); send(8'h83);
      read_reg(3, v);
      check("pre_R3", 32'(v), 32'h2A);
      send(8'hC0);
      check("rsv_ready", 32'(instr_ready), 32'd1);
      send(8'h9F);
      check("null_ready", 32'(instr_ready), 32'd1);
      check("null_out_valid", 32'(out_valid), 32'd0);
      check("null_out_port", 32'(out_port), 32'h2A);
      read_reg(0, v);
      check("post_R0", 32'(v), 32'h2A);
      read_reg(3, v);
      check("post_R3", 32'(v), 32'h2A);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
